uart_fifo_tx: RTL
=================

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data bits per frame.
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning stop-bit length in s_tick units (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 The block SHALL have port clk, input, 1, system clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset: reset = 0 resets the block immediately, regardless of clk.
REQ-005 The block SHALL have port s_tick, input, 1, one-clk enable pulse at 16x the baud rate from the baud generator.
REQ-006 The block SHALL have port empty, input, 1, upstream FIFO empty flag.
REQ-007 The block SHALL have port r_data, input, DBIT, upstream FIFO head word, valid whenever empty = 0.
REQ-008 The block SHALL have port rd, output, 1, one-clk pop request to the upstream FIFO.
REQ-009 The block SHALL have port tx, output, 1, serial line; idle level is 1.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 The block SHALL have port tx_done_tick, output, 1, one-clk pulse at the end of each frame's stop bit.

Function
REQ-012 The block SHALL implement a 4-state FSM with states IDLE, START, DATA and STOP.
REQ-013 The block SHALL, in IDLE with empty = 0, assert rd combinationally for that one cycle, latch r_data into the shift register at the next edge, clear the tick counter, and go to START.
REQ-014 The block SHALL, in IDLE with empty = 1, keep rd = 0, keep tx = 1, and ignore s_tick.
REQ-015 The block SHALL never assert rd outside IDLE and never for more than one consecutive cycle per frame.
REQ-016 The block SHALL, in START, drive tx = 0 for exactly 16 s_tick pulses, then clear the tick counter and the bit counter and go to DATA.
REQ-017 The block SHALL, in DATA, drive tx = the shift register LSB for 16 s_tick pulses per bit, then shift right one place and increment the bit counter.
REQ-018 The block SHALL send data bits LSB first and go to STOP after bit DBIT-1.
REQ-019 The block SHALL, in STOP, drive tx = 1 for SB_TICK s_tick pulses, then pulse tx_done_tick for one clk and return to IDLE.
REQ-020 The block SHALL advance tick counts only on cycles with s_tick = 1; cycles without s_tick hold all counters.
REQ-021 The block SHALL make the tick counter wide enough for SB_TICK-1 and the bit counter ceil(log2(DBIT)) bits wide, with no reliance on wrap-around.
REQ-022 The block SHALL drive tx from a register, with no combinational glitches on the line.
REQ-023 The block SHALL give a frame length of (16 + 16*DBIT + SB_TICK) s_tick pulses; with defaults this is 160.
REQ-024 The block SHALL start the next frame back-to-back: after STOP the block spends exactly one clk in IDLE, popping there if empty = 0.
REQ-025 The block SHALL ignore changes on empty or r_data while busy = 1; the latched word is transmitted unchanged.

Reset
REQ-026 The block SHALL, while reset = 0, force state IDLE, tx = 1, busy = 0, rd = 0, tx_done_tick = 0, and all counters and the shift register to 0.
REQ-027 The block SHALL, on reset asserted mid-frame, abort the frame immediately with tx = 1 asynchronously and no tx_done_tick.
REQ-028 The block SHALL not retransmit the aborted word after reset is released; the next frame pops a new word.

Verification
REQ-029 The bench SHALL cover: s_tick every 4 clk, FIFO holds 0xA5 -> one rd pulse; tx = 0, 1,0,1,0,0,1,0,1, 1 at 16 ticks each (64 clk each); tx_done_tick once after 160 ticks; busy = 0 after.
REQ-030 The bench SHALL cover: FIFO holds 0x00 then 0xFF -> two frames, each with one rd pulse, one idle clk between the end of the first stop bit and the second start bit, and correct bit patterns.
REQ-031 The bench SHALL cover: empty = 1 held for 1000 clk with s_tick running -> tx = 1, rd = 0, busy = 0 throughout.
REQ-032 The bench SHALL cover: reset = 0 driven mid-DATA (bit 3) between clk edges -> tx = 1 at once, busy = 0, no tx_done_tick; on release with empty = 1 the block stays idle.
REQ-033 The bench SHALL cover: SB_TICK = 32, DBIT = 7, word 0x55 -> stop high for 32 ticks, frame of 160 ticks, only 7 data bits sent.
REQ-034 The bench SHALL cover: empty and r_data toggled randomly during a frame -> the transmitted bits match the word latched at the pop, and no extra rd pulses occur.

Source files
------------

// File: rtl/uart_fifo_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_fifo_tx
//   UART transmitter that pulls words from an upstream FIFO. Each frame is one
//   start bit, DBIT data bits (LSB first) and a stop period of SB_TICK s_tick
//   pulses; every start/data bit lasts 16 s_tick pulses (16x oversampled baud).
//
// Parameters
//   DBIT     data bits per frame
//   SB_TICK  stop length in s_tick units (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   s_tick        one-clk enable at 16x baud
//   empty         upstream FIFO empty flag
//   r_data        upstream FIFO head word (valid when empty = 0)
//   rd            one-clk pop request to the FIFO
//   tx            serial line, idles high, driven from a flop
//   busy          high whenever a frame is in progress
//   tx_done_tick  one-clk pulse at the end of each stop period
// -----------------------------------------------------------------------------
module uart_fifo_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd,
  output logic            tx,
  output logic            busy,
  output logic            tx_done_tick
);

  // Tick counter must reach both 15 (bit period) and SB_TICK-1 (stop period).
  localparam int TICK_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] BIT_TICK_LAST  = TW'(15);
  localparam logic [TW-1:0] STOP_TICK_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST       = BW'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q,  tick_d;
  logic [BW-1:0]     bit_q,   bit_d;
  logic [DBIT-1:0]   shreg_q, shreg_d;
  logic              tx_q,    tx_d;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          shreg_d = r_data;
          tick_d  = '0;
          state_d = START;
        end
      end

      START: begin
        if (s_tick) begin
          if (tick_q == BIT_TICK_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (tick_q == BIT_TICK_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_TICK_LAST) begin
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The line level is registered from the *next* state and shift value, so
    // the flop output lines up with the state register instead of lagging it
    // by a clock, while still giving a glitch-free tx.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    rd           = 1'b0;
    tx_done_tick = 1'b0;
    busy         = (state_q != IDLE);
    tx           = tx_q;

    unique case (state_q)
      // Gated by reset so no pop request can escape while reset is held.
      IDLE:    rd = reset & ~empty;
      STOP:    tx_done_tick = s_tick && (tick_q == STOP_TICK_LAST);
      default: ;
    endcase
  end

endmodule
